// File: rtl/matrix_result_serializer_if.sv
// rtl/matrix_result_serializer_if.sv - collector-side and stream-side signals of the result serializer
// master drives the inputs (collector / downstream ready); slave is the serializer itself.
interface matrix_result_serializer_if #(
  parameter int DATA_WIDTH = 16
);
  logic [0:2][0:2][DATA_WIDTH-1:0] in_data;
  logic                            in_valid;
  logic [DATA_WIDTH-1:0]           out_data;
  logic [1:0]                      out_row;
  logic [1:0]                      out_col;
  logic                            out_last;
  logic                            out_valid;
  logic                            out_ready;
  logic                            overflow;
  logic                            clear_overflow;
  logic                            busy;

  modport master (
    output in_data, in_valid, out_ready, clear_overflow,
    input  out_data, out_row, out_col, out_last, out_valid, overflow, busy
  );

  modport slave (
    input  in_data, in_valid, out_ready, clear_overflow,
    output out_data, out_row, out_col, out_last, out_valid, overflow, busy
  );
endinterface

// File: rtl/matrix_result_serializer.sv
// rtl/matrix_result_serializer.sv - ping-pong buffered 3x3 matrix to row-major element stream
// Optional SERIALIZER_RELU_EN clamps negative elements to zero on the output path only.
module matrix_result_serializer #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  matrix_result_serializer_if.slave     bus
);
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [DATA_WIDTH-1:0] mem [0:1][0:8];
  logic [DATA_WIDTH-1:0] in_elem [0:8];

  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] occ;
  logic [3:0] cnt;
  logic [0:0] state;

  logic [DATA_WIDTH-1:0] data_q;
  logic [1:0]            row_q;
  logic [1:0]            col_q;
  logic                  last_q;
  logic                  ovf_q;
  logic                  busy_q;

  logic                  hs;
  logic                  last_hs;
  logic                  capture;
  logic                  drop;
  logic [1:0]            occ_next;
  logic [0:0]            state_next;
  logic [3:0]            cnt_next;
  logic                  load;
  logic                  load_from_in;
  logic                  load_ptr;
  logic [3:0]            load_idx;
  logic [DATA_WIDTH-1:0] load_src;

  function automatic logic [1:0] idx_row(input logic [3:0] idx);
    if (idx >= 4'd6) return 2'd2;
    if (idx >= 4'd3) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [1:0] idx_col(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd3, 4'd6: return 2'd0;
      4'd1, 4'd4, 4'd7: return 2'd1;
      default:          return 2'd2;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] out_xform(input logic [DATA_WIDTH-1:0] v);
`ifdef SERIALIZER_RELU_EN
    return v[DATA_WIDTH-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  for (genvar r = 0; r < 3; r++) begin : g_row
    for (genvar c = 0; c < 3; c++) begin : g_col
      assign in_elem[r*3+c] = bus.in_data[r][c];
    end
  end

  // Freeing the last element frees a slot in the same cycle, so a capture at full occupancy is legal then.
  always_comb begin
    hs       = (state == ST_STREAM) && bus.out_ready;
    last_hs  = hs && (cnt == 4'd8);
    capture  = bus.in_valid && ((occ != 2'd2) || last_hs);
    drop     = bus.in_valid && !capture;
    occ_next = occ - {1'b0, last_hs} + {1'b0, capture};
  end

  // Next element selection; a matrix arriving into an empty pipe is forwarded straight from in_data.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    load         = 1'b0;
    load_from_in = 1'b0;
    load_ptr     = rd_ptr;
    load_idx     = 4'd0;
    if (state == ST_IDLE) begin
      if (capture) begin
        state_next   = ST_STREAM;
        cnt_next     = 4'd0;
        load         = 1'b1;
        load_from_in = 1'b1;
      end
    end else if (hs) begin
      if (!last_hs) begin
        cnt_next = cnt + 4'd1;
        load     = 1'b1;
        load_idx = cnt + 4'd1;
      end else begin
        cnt_next = 4'd0;
        if (occ == 2'd2) begin
          load     = 1'b1;
          load_ptr = ~rd_ptr;
        end else if (capture) begin
          load         = 1'b1;
          load_from_in = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
    end
  end

  assign load_src = load_from_in ? in_elem[load_idx] : mem[load_ptr][load_idx];

  always_ff @(posedge clk) begin
    if (rst_n && capture) begin
      for (int i = 0; i < 9; i++) begin
        mem[wr_ptr][i] <= in_elem[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
      cnt    <= 4'd0;
      state  <= ST_IDLE;
      data_q <= '0;
      row_q  <= 2'd0;
      col_q  <= 2'd0;
      last_q <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      if (capture) wr_ptr <= ~wr_ptr;
      if (last_hs) rd_ptr <= ~rd_ptr;
      occ    <= occ_next;
      busy_q <= (occ_next != 2'd0);
      state  <= state_next;
      cnt    <= cnt_next;
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (bus.clear_overflow) begin
        ovf_q <= 1'b0;
      end
      if (load) begin
        data_q <= out_xform(load_src);
        row_q  <= idx_row(load_idx);
        col_q  <= idx_col(load_idx);
        last_q <= (load_idx == 4'd8);
      end else if (state_next == ST_IDLE) begin
        data_q <= '0;
        row_q  <= 2'd0;
        col_q  <= 2'd0;
        last_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_row   = row_q;
  assign bus.out_col   = col_q;
  assign bus.out_last  = last_q;
  assign bus.out_valid = (state == ST_STREAM);
  assign bus.overflow  = ovf_q;
  assign bus.busy      = busy_q;
endmodule
